// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that time-shares one external SLICE-bit combinational adder to perform
// a WIDTH-bit add/subtract one slice per clock, LSB slice first, with start/done handshake.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             done_ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_s,
  input  logic             add_cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // b already inverted for subtract
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = done_q;
    busy_d   = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[cnt_q*SLICE +: SLICE] = add_s;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          cout_d  = add_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[SLICE-1] != a_q[WIDTH-1]);
          zero_d  = (result_d == '0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A start on the ack edge is dropped; the next one is taken from IDLE.
        if (done_ack) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  logic run;
  assign run     = (state_q == S_RUN);
  assign add_a   = run ? a_q[cnt_q*SLICE +: SLICE] : '0;
  assign add_b   = run ? b_q[cnt_q*SLICE +: SLICE] : '0;
  assign add_cin = run ? carry_q : 1'b0;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl; models the shared 4-bit adder and
// checks results, flags, latency, handshake and reset behaviour against hand values.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0, done_ack = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf, zero;
  logic [15:0] result;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;

  int total = 0;
  int bad   = 0;
  logic cin_log [4];

  always #5 clk = ~clk;

  // Shared combinational adder slice.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_add_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .done_ack(done_ack), .busy(busy), .done(done), .result(result), .cout(cout),
    .ovf(ovf), .zero(zero), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // Drives a start on a negedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                          input logic tc);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; logs add_cin per RUN slice.
  task automatic wait_done(output int n);
    int idx = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !done && idx < 4) begin
        cin_log[idx] = add_cin;
        idx++;
      end
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: done=%0b after %0d edges, required 1", done, n);
    end
  endtask

  task automatic ack();
    done_ack = 1'b1;
    @(posedge clk); #1;
    done_ack = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [15:0] er, input logic ec,
                          input logic eo, input logic ez);
    total++;
    if (result !== er) begin bad++; $display("FAIL %s result: got %h required %h", nm, result, er); end
    total++;
    if (cout !== ec) begin bad++; $display("FAIL %s cout: got %b required %b", nm, cout, ec); end
    total++;
    if (ovf !== eo) begin bad++; $display("FAIL %s ovf: got %b required %b", nm, ovf, eo); end
    total++;
    if (zero !== ez) begin bad++; $display("FAIL %s zero: got %b required %b", nm, zero, ez); end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, cout, ovf, zero, result} !== 21'd0) begin
      bad++; $display("FAIL reset outputs: got %h required 0", {busy, done, cout, ovf, zero, result});
    end
    total++;
    if ({add_a, add_b, add_cin} !== 9'd0) begin
      bad++; $display("FAIL reset adder port: got %h required 0", {add_a, add_b, add_cin});
    end
    @(negedge clk); rst_n = 1'b1;
    // Stray ack in IDLE must do nothing.
    done_ack = 1'b1; @(negedge clk); done_ack = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle ack: busy got %b required 0", busy); end
  endtask

  task automatic test_basic_add();
    int n;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL add busy: got %b required 1", busy); end
    wait_done(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL add latency: got %0d required 4", n); end
    check_op("add1", 16'h5555, 1'b0, 1'b0, 1'b0);
    ack();
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL add ack: busy/done got %b required 00", {busy, done}); end
  endtask

  task automatic test_carry();
    int n;
    start_op(16'h000C, 16'h0003, 1'b0, 1'b1);
    wait_done(n);
    check_op("carry", 16'h0010, 1'b0, 1'b0, 1'b0);
    ack();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    check_op("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    ack();
  endtask

  task automatic test_sub();
    int n;
    start_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    wait_done(n);
    check_op("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    ack();
    start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_done(n);
    check_op("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    ack();
  endtask

  task automatic test_overflow();
    int n;
    logic [3:0] got;
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    check_op("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
    got = {cin_log[3], cin_log[2], cin_log[1], cin_log[0]};
    total++;
    if (got !== 4'b1110) begin bad++; $display("FAIL slice add_cin s3..s0: got %b required 1110", got); end
    ack();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    a = 16'hAAAA; b = 16'h1111; start = 1'b1;     // start during RUN
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b1; start = 1'b1;  // start during DONE
    repeat (2) @(posedge clk); #1;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL hold done: got %b required 1", done); end
    check_op("hold", 16'h5555, 1'b0, 1'b0, 1'b0);
    done_ack = 1'b1;                               // start still high on ack edge
    @(posedge clk); #1;
    done_ack = 1'b0; start = 1'b0;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ack with start: busy/done got %b required 00", {busy, done}); end
    repeat (2) @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start queued: busy got %b required 0", busy); end
    total++;
    if (result !== 16'h5555) begin bad++; $display("FAIL idle hold result: got %h required 5555", result); end
  endtask

  task automatic test_mid_reset();
    int n;
    start_op(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;                 // slices 0 and 1 written
    total++;
    if (result[7:0] !== 8'h00) begin bad++; $display("FAIL partial result: got %h required xx00", result); end
    rst_n = 1'b0; #1;
    total++;
    if ({busy, done, result} !== 18'd0) begin
      bad++; $display("FAIL mid reset: busy/done/result got %h required 0", {busy, done, result});
    end
    @(negedge clk); rst_n = 1'b1;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (n != 4) begin bad++; $display("FAIL post-reset latency: got %0d required 4", n); end
    check_op("post_reset", 16'h3333, 1'b0, 1'b0, 1'b0);
    ack();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
